moving_average_filter: RTL and testbench

Boxcar (moving-average) filter placed directly downstream of the 5-tap moving-median stage in the AverageAndMedian instrument. It smooths the median-filtered stream over a power-of-two window of the most recent accepted samples, using a circular sample buffer and a running sum. The block adds a sample-valid qualifier and a window-filled flag so downstream logic can ignore the start-up transient.

---
 rtl/avg_pkg.sv | 12 +
 rtl/sample_ring.sv | 33 +++
 rtl/moving_average_filter.sv | 71 +++++++
 tb/tb_moving_average_filter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared sizing for the AverageAndMedian filter chain (median wrapper and boxcar stage).
package avg_pkg;

   localparam int WIDTH_DEFAULT    = 16;
   localparam int LOG2_LEN_DEFAULT = 3;

   // Running sum needs LOG2_LEN guard bits so N full-scale samples never overflow.
   function automatic int sum_width(input int width, input int log2_len);
      return width + log2_len;
   endfunction

endpackage

// File: rtl/sample_ring.sv
// Circular store of the last N accepted samples; exposes the entry about to be overwritten.
module sample_ring
   import avg_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEFAULT,
   parameter int LOG2_LEN = LOG2_LEN_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             write_en,
   input  logic [WIDTH-1:0] write_data,
   output logic [WIDTH-1:0] oldest
);

   localparam int N = 1 << LOG2_LEN;

   logic [WIDTH-1:0]    ring [N];
   logic [LOG2_LEN-1:0] wr_ptr;

   // The pointer is exactly LOG2_LEN bits, so N-1 -> 0 wraps for free.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         for (int i = 0; i < N; i++) ring[i] <= '0;
      end else if (write_en) begin
         ring[wr_ptr] <= write_data;
         wr_ptr       <= wr_ptr + LOG2_LEN'(1);
      end
   end

   assign oldest = ring[wr_ptr];

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar filter over the last 2^LOG2_LEN accepted samples, using a running sum and a sample ring.
module moving_average_filter
   import avg_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEFAULT,
   parameter int LOG2_LEN = LOG2_LEN_DEFAULT
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    InValid,
   input  logic signed [WIDTH-1:0] Input,
   output logic signed [WIDTH-1:0] Output,
   output logic                    OutValid,
   output logic                    Filled
);

   localparam int SW = sum_width(WIDTH, LOG2_LEN);
   localparam logic [LOG2_LEN:0] FULL = {1'b1, {LOG2_LEN{1'b0}}};

   // InValid is a valid-only qualifier with no backpressure: each high cycle consumes one
   // sample; OutValid pulses once per consumed sample, one cycle after its sum update.

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] in_ext;
   logic signed [SW-1:0] old_ext;
   logic [WIDTH-1:0]     oldest;
   logic [LOG2_LEN:0]    fill_count;
   logic                 accept_d;

   sample_ring #(
      .WIDTH    (WIDTH),
      .LOG2_LEN (LOG2_LEN)
   ) u_ring (
      .Clk        (Clk),
      .Reset      (Reset),
      .write_en   (InValid),
      .write_data (Input),
      .oldest     (oldest)
   );

   assign in_ext  = {{LOG2_LEN{Input[WIDTH-1]}}, Input};
   assign old_ext = {{LOG2_LEN{oldest[WIDTH-1]}}, oldest};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sum        <= '0;
         fill_count <= '0;
         accept_d   <= 1'b0;
      end else begin
         accept_d <= InValid;
         if (InValid) begin
            sum <= sum + in_ext - old_ext;
            if (fill_count != FULL) fill_count <= fill_count + (LOG2_LEN+1)'(1);
         end
      end
   end

   // Arithmetic shift floors toward -infinity; the quotient always fits WIDTH.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Output   <= '0;
         OutValid <= 1'b0;
      end else begin
         OutValid <= accept_d;
         if (accept_d) Output <= WIDTH'(sum >>> LOG2_LEN);
      end
   end

   assign Filled = (fill_count == FULL);

endmodule

// File: tb/tb_moving_average_filter.sv
// Bench for moving_average_filter: queue-based boxcar model, per-cycle compare, directed and random stimulus.
module tb_moving_average_filter;

   localparam int W = 16;
   localparam int L = 3;
   localparam int N = 1 << L;

   logic                Clk = 1'b0;
   logic                Reset;
   logic                InValid;
   logic signed [W-1:0] Input;
   logic signed [W-1:0] Output;
   logic                OutValid;
   logic                Filled;

   int assertions = 0;
   int failures   = 0;
   bit checking   = 0;

   // Model state: last N accepted samples (zeros before fill), accepts seen, pending result.
   int             model_hist[$];
   int             model_count;
   int             exp_out;
   bit             exp_valid;
   bit             pend;
   int             pend_val;
   logic [W-1:0]   exp_q[$];
   int             got_q[$];

   always #5 Clk = ~Clk;

   moving_average_filter #(.WIDTH(W), .LOG2_LEN(L)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .InValid  (InValid),
      .Input    (Input),
      .Output   (Output),
      .OutValid (OutValid),
      .Filled   (Filled)
   );

   function automatic int floor_div(input int s);
      if (s >= 0) return s / N;
      return -((-s + N - 1) / N);
   endfunction

   function automatic int hist_sum();
      int s = 0;
      foreach (model_hist[i]) s += model_hist[i];
      return s;
   endfunction

   task automatic model_reset();
      model_hist.delete();
      for (int i = 0; i < N; i++) model_hist.push_back(0);
      model_count = 0;
      exp_out     = 0;
      exp_valid   = 0;
      pend        = 0;
      pend_val    = 0;
      exp_q.delete();
   endtask

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_next(input string name, input int v);
      if (got_q.size() == 0) begin
         assertions++;
         failures++;
         $display("FAIL %s: no output observed, expected %0d", name, v);
      end else begin
         check(name, got_q.pop_front(), v);
      end
   endtask

   task automatic drive(input bit valid, input int v);
      InValid = valid;
      Input   = W'(v);
      @(posedge Clk);
      #1;
      InValid = 1'b0;
   endtask

   task automatic do_reset(input int v);
      Reset   = 1'b1;
      InValid = 1'b1;
      Input   = W'(v);
      @(posedge Clk);
      #1;
      Reset   = 1'b0;
      InValid = 1'b0;
      got_q.delete();
   endtask

   // Behavioural model, advanced on each rising edge from the inputs held there.
   initial begin
      model_reset();
      forever begin
         @(posedge Clk);
         if (Reset) begin
            model_reset();
         end else begin
            exp_valid = pend;
            if (pend) exp_out = pend_val;
            pend = InValid;
            if (InValid) begin
               model_hist.push_back(int'(Input));
               void'(model_hist.pop_front());
               pend_val = floor_div(hist_sum());
               exp_q.push_back(pend_val[W-1:0]);
               if (model_count < N) model_count++;
            end
         end
      end
   end

   // Per-cycle compare on the falling edge.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge Clk);
         if (checking) begin
            check("out_valid", OutValid, exp_valid);
            check("filled", Filled, model_count == N);
            check("output", Output, exp_out);
            if (OutValid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  assertions++;
                  failures++;
                  $display("FAIL scoreboard: unexpected output %0d", Output);
               end else begin
                  e = exp_q.pop_front();
                  check("scoreboard", Output, $signed(e));
               end
               got_q.push_back(int'(Output));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vals[$];
      Reset   = 1'b1;
      InValid = 1'b0;
      Input   = '0;
      @(posedge Clk);
      #1;
      checking = 1;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_output", Output, 0);
      check("reset_out_valid", OutValid, 0);
      check("reset_filled", Filled, 0);
      Reset = 1'b0;
      drive(0, 0);
      check("post_reset_output", Output, 0);
      check("post_reset_filled", Filled, 0);

      // Step fill at 100.
      do_reset(0);
      for (int i = 0; i < N; i++) begin
         drive(1, 100);
         check("fill_flag", Filled, i == N - 1);
      end
      drive(0, 0);
      check("fill_latency_output", Output, 100);
      check("fill_latency_valid", OutValid, 1);
      drive(0, 0);
      vals = '{12, 25, 37, 50, 62, 75, 87, 100};
      foreach (vals[i]) expect_next("step_fill", vals[i]);

      // Eviction of the oldest sample.
      drive(1, 900);
      drive(0, 0);
      drive(0, 0);
      expect_next("eviction", 200);
      check("eviction_filled", Filled, 1);

      // Reset mid-run with a sample that must be discarded.
      do_reset(0);
      for (int i = 0; i < N; i++) drive(1, 100);
      drive(0, 0);
      drive(0, 0);
      do_reset(500);
      check("midrun_reset_output", Output, 0);
      check("midrun_reset_filled", Filled, 0);
      check("midrun_reset_valid", OutValid, 0);
      drive(0, 0);
      check("midrun_release_output", Output, 0);
      drive(1, 80);
      drive(0, 0);
      drive(0, 0);
      expect_next("after_reset_first", 10);

      // Negative values floor toward -infinity.
      do_reset(0);
      drive(1, -1);
      for (int i = 0; i < N; i++) drive(1, 0);
      drive(0, 0);
      drive(0, 0);
      for (int i = 0; i < N; i++) expect_next("neg_floor", -1);
      expect_next("neg_evicted", 0);

      // Full-scale extremes.
      do_reset(0);
      for (int i = 0; i < N; i++) drive(1, 32767);
      for (int i = 0; i < N; i++) drive(1, -32768);
      drive(0, 0);
      drive(0, 0);
      for (int i = 0; i < N - 1; i++) void'(got_q.pop_front());
      expect_next("max_extreme", 32767);
      for (int i = 0; i < N - 1; i++) void'(got_q.pop_front());
      expect_next("min_extreme", -32768);

      // Gaps between accepts.
      do_reset(0);
      for (int i = 0; i < N; i++) begin
         drive(1, 8);
         drive(0, 0);
      end
      drive(0, 0);
      for (int i = 1; i <= N; i++) expect_next("gaps", i);

      // Random traffic with occasional resets.
      do_reset(0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(0, 65535)));
         else drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 65535)));
      end
      drive(0, 0);
      drive(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
